// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter for the shared MMIO port. Every access is a
// fixed IDLE -> ACCESS -> RESP sequence; illegal accesses never reach the device.
module mmio_arbiter #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] IDLE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [DATA_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_done,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [DATA_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_done,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic [DATA_W-1:0] Address,
   output logic [DATA_W-1:0] WriteData,
   input  logic [DATA_W-1:0] DataIo
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t r_state;
   logic   r_last1;
   logic   r_win;
   logic   r_we;
   logic   r_legal;

   logic              w_pick1;
   logic              w_we;
   logic [DATA_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_legal;

   // Writes only to output registers, reads only from input registers.
   function automatic logic f_legal(input logic we, input logic [DATA_W-1:0] a);
      if (we)
         return (a == DATA_W'(32'hFFFF_FF0C)) || (a == DATA_W'(32'hFFFF_FF10)) ||
                (a == DATA_W'(32'hFFFF_FF14)) || (a == DATA_W'(32'hFFFF_FF18));
      else
         return (a == DATA_W'(32'hFFFF_FF00)) || (a == DATA_W'(32'hFFFF_FF04)) ||
                (a == DATA_W'(32'hFFFF_FF08));
   endfunction

   assign w_pick1 = m1_req && (!m0_req || !r_last1);
   assign w_we    = w_pick1 ? m1_we    : m0_we;
   assign w_addr  = w_pick1 ? m1_addr  : m0_addr;
   assign w_wdata = w_pick1 ? m1_wdata : m0_wdata;
   assign w_legal = f_legal(w_we, w_addr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_last1   <= 1'b1;
         r_win     <= 1'b0;
         r_we      <= 1'b0;
         r_legal   <= 1'b0;
         Address   <= IDLE_ADDR;
         WriteData <= '0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_done   <= 1'b0;
         m1_done   <= 1'b0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (m0_req || m1_req) begin
                  r_win   <= w_pick1;
                  r_last1 <= w_pick1;
                  r_we    <= w_we;
                  r_legal <= w_legal;
                  if (w_legal) begin
                     Address   <= w_addr;
                     WriteData <= w_we ? w_wdata : '0;
                     m0_gnt    <= !w_pick1;
                     m1_gnt    <= w_pick1;
                  end
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // Park immediately: the device commits on every edge Address matches.
               Address   <= IDLE_ADDR;
               WriteData <= '0;
               m0_gnt    <= 1'b0;
               m1_gnt    <= 1'b0;
               if (r_win) begin
                  m1_done <= 1'b1;
                  m1_err  <= !r_legal;
                  if (!r_legal)  m1_rdata <= '0;
                  else if (!r_we) m1_rdata <= DataIo;
               end else begin
                  m0_done <= 1'b1;
                  m0_err  <= !r_legal;
                  if (!r_legal)  m0_rdata <= '0;
                  else if (!r_we) m0_rdata <= DataIo;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               m0_done <= 1'b0;
               m1_done <= 1'b0;
               m0_err  <= 1'b0;
               m1_err  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter with a small MMIO device model (output regs
// commit on every edge Address matches; input regs feed DataIo).
module tb_mmio_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata, Address, WriteData, DataIo;

   int checks = 0;
   int failures = 0;

   logic [31:0] led1 = '0, led2 = '0, seg1 = '0, seg2 = '0;
   logic [31:0] in00 = 32'h0000_0011, in04 = 32'h0000_00A5, in08 = 32'h0000_0022;
   int          wr_cnt = 0;

   always #5 clk = ~clk;

   mmio_arbiter #(.DATA_W(32), .IDLE_ADDR(32'h0)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .Address(Address), .WriteData(WriteData), .DataIo(DataIo)
   );

   assign DataIo = (Address == 32'hFFFF_FF00) ? in00 :
                   (Address == 32'hFFFF_FF04) ? in04 :
                   (Address == 32'hFFFF_FF08) ? in08 : 32'h0;

   always @(posedge clk) begin
      case (Address)
         32'hFFFF_FF0C: begin led1 <= WriteData; wr_cnt <= wr_cnt + 1; end
         32'hFFFF_FF10: begin led2 <= WriteData; wr_cnt <= wr_cnt + 1; end
         32'hFFFF_FF14: begin seg1 <= WriteData; wr_cnt <= wr_cnt + 1; end
         32'hFFFF_FF18: begin seg2 <= WriteData; wr_cnt <= wr_cnt + 1; end
         default: ;
      endcase
   end

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++; if (Address !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", Address, 32'h0); end
      checks++; if (WriteData !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", WriteData); end
      checks++;
      if ({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err} !== 6'b0) begin
         failures++; $display("FAIL reset_ctl got=%b exp=000000", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err});
      end
      checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata); end
   endtask

   task automatic test_m0_write;
      @(posedge clk); #1;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'hFFFF_FF0C; m0_wdata = 32'h0000_005A;
      @(posedge clk); #1;
      checks++; if (Address !== 32'hFFFF_FF0C) begin failures++; $display("FAIL wr_addr got=%h exp=ffffff0c", Address); end
      checks++; if (WriteData !== 32'h5A) begin failures++; $display("FAIL wr_wdata got=%h exp=5a", WriteData); end
      checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || m0_done !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b%b exp=100", m0_gnt, m1_gnt, m0_done); end
      @(posedge clk); #1;
      checks++; if (m0_done !== 1'b1 || m0_err !== 1'b0) begin failures++; $display("FAIL wr_done got=%b err=%b exp=1/0", m0_done, m0_err); end
      checks++; if (Address !== 32'h0 || m0_gnt !== 1'b0) begin failures++; $display("FAIL wr_park got=%h gnt=%b exp=0/0", Address, m0_gnt); end
      checks++; if (led1 !== 32'h5A || wr_cnt !== 1) begin failures++; $display("FAIL wr_led1 got=%h cnt=%0d exp=5a/1", led1, wr_cnt); end
      m0_req = 1'b0;
      @(posedge clk); #1;
      checks++; if (m0_done !== 1'b0) begin failures++; $display("FAIL wr_done_pulse got=%b exp=0", m0_done); end
   endtask

   task automatic test_m1_read;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hFFFF_FF04; m1_wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      checks++; if (Address !== 32'hFFFF_FF04 || WriteData !== 32'h0) begin failures++; $display("FAIL rd_addr got=%h/%h exp=ffffff04/0", Address, WriteData); end
      checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin failures++; $display("FAIL rd_gnt got=%b%b exp=10", m1_gnt, m0_gnt); end
      @(posedge clk); #1;
      checks++; if (m1_rdata !== 32'hA5 || m1_done !== 1'b1 || m1_err !== 1'b0) begin failures++; $display("FAIL rd_data got=%h done=%b err=%b exp=a5/1/0", m1_rdata, m1_done, m1_err); end
      checks++; if (m0_done !== 1'b0 || m0_rdata !== 32'h0 || m0_err !== 1'b0) begin failures++; $display("FAIL rd_m0_quiet got=%b/%h/%b exp=0/0/0", m0_done, m0_rdata, m0_err); end
      checks++; if (wr_cnt !== 1) begin failures++; $display("FAIL rd_nowrite got=%0d exp=1", wr_cnt); end
      m1_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_simultaneous;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hFFFF_FF00;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hFFFF_FF08;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if (m0_gnt !== (k % 2 == 0) || m1_gnt !== (k % 2 == 1)) begin
            failures++; $display("FAIL rr_gnt%0d got=%b%b exp=%b%b", k, m0_gnt, m1_gnt, k % 2 == 0, k % 2 == 1);
         end
         @(posedge clk); #1;
         checks++;
         if (m0_done !== (k % 2 == 0) || m1_done !== (k % 2 == 1)) begin
            failures++; $display("FAIL rr_done%0d got=%b%b exp=%b%b", k, m0_done, m1_done, k % 2 == 0, k % 2 == 1);
         end
         if (k == 3) begin m0_req = 1'b0; m1_req = 1'b0; end
         @(posedge clk); #1;
      end
      checks++; if (m0_rdata !== 32'h11 || m1_rdata !== 32'h22) begin failures++; $display("FAIL rr_rdata got=%h/%h exp=11/22", m0_rdata, m1_rdata); end
   endtask

   task automatic test_illegal;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hFFFF_FF14;
      @(posedge clk); #1;
      checks++; if (Address !== 32'h0 || m0_gnt !== 1'b0) begin failures++; $display("FAIL ill_rd_park got=%h gnt=%b exp=0/0", Address, m0_gnt); end
      @(posedge clk); #1;
      checks++; if (m0_done !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin failures++; $display("FAIL ill_rd got=%b/%b/%h exp=1/1/0", m0_done, m0_err, m0_rdata); end
      m0_req = 1'b0;
      @(posedge clk); #1;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hFFFF_FF04; m1_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      checks++; if (Address !== 32'h0 || m1_gnt !== 1'b0) begin failures++; $display("FAIL ill_wr_park got=%h gnt=%b exp=0/0", Address, m1_gnt); end
      @(posedge clk); #1;
      checks++; if (m1_done !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0) begin failures++; $display("FAIL ill_wr got=%b/%b/%h exp=1/1/0", m1_done, m1_err, m1_rdata); end
      m1_req = 1'b0;
      @(posedge clk); #1;
      checks++; if (wr_cnt !== 1 || seg1 !== 32'h0) begin failures++; $display("FAIL ill_nowrite got=%0d seg1=%h exp=1/0", wr_cnt, seg1); end
   endtask

   task automatic test_reset_mid;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'hFFFF_FF10; m0_wdata = 32'h0000_0077;
      @(posedge clk); #1;
      checks++; if (Address !== 32'hFFFF_FF10) begin failures++; $display("FAIL mid_addr got=%h exp=ffffff10", Address); end
      #2 reset = 1'b0;
      #1;
      checks++; if (Address !== 32'h0 || m0_gnt !== 1'b0) begin failures++; $display("FAIL mid_async got=%h gnt=%b exp=0/0", Address, m0_gnt); end
      m0_req = 1'b0;
      @(posedge clk); #1;
      checks++; if (m0_done !== 1'b0) begin failures++; $display("FAIL mid_nodone got=%b exp=0", m0_done); end
      @(posedge clk); #1;
      reset = 1'b1;
      checks++; if (led2 !== 32'h0 || wr_cnt !== 1) begin failures++; $display("FAIL mid_led2 got=%h cnt=%0d exp=0/1", led2, wr_cnt); end
      @(posedge clk); #1;
      m0_req = 1'b1; m0_wdata = 32'h0000_0099;
      @(posedge clk); #1;
      checks++; if (Address !== 32'hFFFF_FF10 || m0_gnt !== 1'b1) begin failures++; $display("FAIL mid_retry got=%h gnt=%b exp=ffffff10/1", Address, m0_gnt); end
      @(posedge clk); #1;
      checks++; if (m0_done !== 1'b1 || m0_err !== 1'b0 || led2 !== 32'h99) begin failures++; $display("FAIL mid_retry_done got=%b/%b/%h exp=1/0/99", m0_done, m0_err, led2); end
      m0_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_m0_write();
      test_m1_read();
      test_simultaneous();
      test_illegal();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter that shares the single MMIO device port (Address/WriteData out, DataIo in) between the CPU data path (master 0) and the debug/UART loader (master 1). It serialises accesses into fixed 3-cycle transactions with round-robin priority. It parks the device address on a neutral value between accesses, because the MMIO block commits a write on every clock edge at which Address matches an output register. It also rejects illegal accesses before they reach the device.

## Interface
Parameters:
- IDLE_ADDR, 32'h0000_0000, parking address driven whenever no access is in progress; must decode to no MMIO register
- DATA_W, 32, address/data width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  request, held high until the matching done
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req is high
- m0_addr / m1_addr  in  32  byte address; stable while req is high
- m0_wdata / m1_wdata  in  32  write data; stable while req is high
- m0_gnt / m1_gnt  out  1  high during that master's ACCESS cycle
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read result; held until that master's next done
- m0_err / m1_err  out  1  valid with done: access rejected
- Address  out  32  to MMIO Address
- WriteData  out  32  to MMIO WriteData
- DataIo  in  32  from MMIO read mux

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Any req: latch the winner's we/addr/wdata and compute legality, then go to ACCESS.
  - Both req: grant the master not recorded in the last-grant register.
  - The last-grant register updates on every grant. After reset it holds m1, so m0 wins first.
- Legality:
  - Legal write addresses: ffff_ff0c, ffff_ff10, ffff_ff14, ffff_ff18.
  - Legal read addresses: ffff_ff00, ffff_ff04, ffff_ff08.
  - Any other combination is illegal, including a read of an output register (it would clobber it), a write of an input register, and any other address.
- ACCESS (1 cycle), legal access:
  - gnt of the winner = 1.
  - Address = latched addr.
  - WriteData = latched wdata on a write; 0 on a read.
  - On a read, DataIo is captured into the winner's rdata at the closing edge.
- ACCESS, illegal access:
  - Address stays IDLE_ADDR and gnt stays 0.
  - The winner's rdata is set to 0.
- RESP (1 cycle): winner's done = 1; err = 1 if illegal, else 0. Then go to IDLE.
- The non-winning master's outputs are unchanged throughout.
- Requester rule: drop req in the cycle after done. A req still high in IDLE is treated as a new transaction.

## Timing
- Reset values: Address = IDLE_ADDR; WriteData = 0; all gnt, done, err = 0; all rdata = 0; state = IDLE.
- Reset assertion is asynchronous and takes effect immediately, including mid-ACCESS.
  - The in-flight transaction is discarded: no done pulse.
  - Address returns to IDLE_ADDR without waiting for a clock.
- Address and WriteData are registered. Relative to the edge N at which req is sampled in IDLE:
  - Address holds the target for exactly cycle N..N+1.
  - The MMIO write commits at edge N+1.
  - rdata is valid from edge N+1.
  - done is high in cycle N+1..N+2.
  - IDLE resumes at N+2, so the next request is sampled at edge N+3 at the earliest.
- Throughput: one transaction per 3 cycles. The same 3-cycle latency applies to illegal accesses.
- A req arriving during ACCESS/RESP waits and is arbitrated at the next IDLE.
- Exactly one device write per legal write transaction. Address ≠ IDLE_ADDR for exactly one cycle per legal transaction.

## Test plan
- Reset: hold reset low, then release → all outputs at reset values; Address = 0000_0000.
- m0 write: m0 writes ffff_ff0c with data 0x0000_005A → Address = ffff_ff0c and WriteData = 0x5A for one cycle; m0_done pulses one cycle later; m0_err = 0; downstream MMIO Led1 = 0x5A.
- m1 read: DataIo = 0x0000_00A5 at ffff_ff04 → m1_rdata = 0x0000_00A5; m1_done pulse; m1_err = 0; m0 outputs unchanged.
- Simultaneous requests: m0 and m1 request continuously, with each re-requesting the cycle after its done → grant order m0, m1, m0, m1; each transaction 3 cycles apart.
- Illegal accesses: m0 reads ffff_ff14 → Address stays 0 throughout, m0_rdata = 0, m0_err = 1 with done, Seg1 unchanged. m1 writes 0x1234_5678 → m1_err = 1.
- Reset mid-transaction: assert reset during ACCESS of an m0 write to ffff_ff10 → Address is 0 immediately, no m0_done, Led2 not written; after release, a fresh m0 request completes normally.
